// File: rtl/a2d_rr_sched.sv
// a2d_rr_sched: round-robin scheduler for the shared SPI A2D.
// Each nxt pulse runs one two-transaction conversion (command, then read)
// of the next channel in the order left load cell, right load cell,
// steering pot, battery, and holds the latest 12-bit result per channel.
// Optional build macro A2D_LD_FILT_EN: the two load-cell registers become a
// 1st-order IIR (new = old + (sample - old)/4), seeded raw by the first
// capture after reset. Steering pot and battery are always raw.
module a2d_rr_sched #(
   parameter logic [2:0] CHNL_LFT   = 3'd0,
   parameter logic [2:0] CHNL_RGHT  = 3'd4,
   parameter logic [2:0] CHNL_STEER = 3'd5,
   parameter logic [2:0] CHNL_BATT  = 3'd6,
   parameter int         GAP_CYC    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        nxt,
   output logic        wrt,
   output logic [15:0] cmd,
   input  logic        done,
   input  logic [15:0] rd_data,
   output logic        busy,
   output logic        cnv_cmplt,
   output logic        rnd_cmplt,
   output logic [11:0] lft_ld,
   output logic [11:0] rght_ld,
   output logic [11:0] steer_pot,
   output logic [11:0] batt
);

   localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_WAIT_CMD, S_GAP, S_RD, S_WAIT_RD
   } state_t;

   state_t         r_state;
   logic [1:0]     r_ptr;
   logic [GW-1:0]  r_gap_cnt;
   logic           r_wrt;
   logic [15:0]    r_cmd;
   logic           r_busy;
   logic           r_cnv;
   logic           r_rnd;
   logic [11:0]    r_lft;
   logic [11:0]    r_rght;
   logic [11:0]    r_steer;
   logic [11:0]    r_batt;
   logic [2:0]     w_chnl;
   logic [11:0]    w_smp;
   logic           w_unused;

`ifdef A2D_LD_FILT_EN
   logic           r_lft_seed;
   logic           r_rght_seed;

   // One IIR step: old + (sample - old) >>> 2, evaluated in 13-bit signed.
   // The result always lies between old and sample, so 12 bits suffice.
   function automatic logic [11:0] iir_upd(input logic [11:0] old, input logic [11:0] smp);
      logic signed [12:0] d;
      d = $signed({1'b0, smp}) - $signed({1'b0, old});
      iir_upd = old + 12'(d >>> 2);
   endfunction
`endif

   // Upper nibble of the SPI response carries no result bits.
   assign w_unused = ^rd_data[15:12];
   assign w_smp    = rd_data[11:0];

   // Map the round-robin pointer onto the A2D channel number.
   always_comb begin
      w_chnl = CHNL_LFT;
      case (r_ptr)
         2'd0:    w_chnl = CHNL_LFT;
         2'd1:    w_chnl = CHNL_RGHT;
         2'd2:    w_chnl = CHNL_STEER;
         default: w_chnl = CHNL_BATT;
      endcase
   end

   // Conversion sequencer with registered strobes and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_ptr     <= 2'd0;
         r_gap_cnt <= '0;
         r_wrt     <= 1'b0;
         r_cmd     <= 16'h0000;
         r_busy    <= 1'b0;
         r_cnv     <= 1'b0;
         r_rnd     <= 1'b0;
         r_lft     <= 12'h000;
         r_rght    <= 12'h000;
         r_steer   <= 12'h000;
         r_batt    <= 12'h000;
`ifdef A2D_LD_FILT_EN
         r_lft_seed  <= 1'b0;
         r_rght_seed <= 1'b0;
`endif
      end else begin
         r_wrt <= 1'b0;
         r_cnv <= 1'b0;
         r_rnd <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (nxt) begin
                  r_state <= S_CMD;
                  r_wrt   <= 1'b1;
                  r_busy  <= 1'b1;
                  r_cmd   <= {2'b00, w_chnl, 11'h000};
               end
            end
            // SPI needs more than one clock, so done is not looked at here.
            S_CMD: r_state <= S_WAIT_CMD;
            // Response to the command transaction is meaningless; drop it.
            S_WAIT_CMD: begin
               if (done) begin
                  r_state   <= S_GAP;
                  r_gap_cnt <= '0;
               end
            end
            // Give SS_n time to recover before the read transaction.
            S_GAP: begin
               if (r_gap_cnt == GW'(GAP_CYC - 1)) begin
                  r_state <= S_RD;
                  r_wrt   <= 1'b1;
               end else begin
                  r_gap_cnt <= r_gap_cnt + 1'b1;
               end
            end
            S_RD: r_state <= S_WAIT_RD;
            S_WAIT_RD: begin
               if (done) begin
                  case (r_ptr)
                     2'd0: begin
`ifdef A2D_LD_FILT_EN
                        r_lft      <= r_lft_seed ? iir_upd(r_lft, w_smp) : w_smp;
                        r_lft_seed <= 1'b1;
`else
                        r_lft <= w_smp;
`endif
                     end
                     2'd1: begin
`ifdef A2D_LD_FILT_EN
                        r_rght      <= r_rght_seed ? iir_upd(r_rght, w_smp) : w_smp;
                        r_rght_seed <= 1'b1;
`else
                        r_rght <= w_smp;
`endif
                     end
                     2'd2:    r_steer <= w_smp;
                     default: r_batt  <= w_smp;
                  endcase
                  r_cnv   <= 1'b1;
                  r_rnd   <= (r_ptr == 2'd3);
                  r_ptr   <= r_ptr + 2'd1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign wrt       = r_wrt;
   assign cmd       = r_cmd;
   assign busy      = r_busy;
   assign cnv_cmplt = r_cnv;
   assign rnd_cmplt = r_rnd;
   assign lft_ld    = r_lft;
   assign rght_ld   = r_rght;
   assign steer_pot = r_steer;
   assign batt      = r_batt;

endmodule

// File: tb/tb_a2d_rr_sched.sv
// Bench for a2d_rr_sched: directed scenarios with literal expectations plus
// a randomized phase, all continuously compared against a timestamp-based
// reference model of the scheduler.
module tb_a2d_rr_sched;

   localparam int GAP = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        nxt;
   logic        done;
   logic [15:0] rd_data;
   logic        wrt;
   logic [15:0] cmd;
   logic        busy;
   logic        cnv_cmplt;
   logic        rnd_cmplt;
   logic [11:0] lft_ld;
   logic [11:0] rght_ld;
   logic [11:0] steer_pot;
   logic [11:0] batt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   a2d_rr_sched #(.GAP_CYC(GAP)) dut (
      .clk(clk), .rst(rst), .nxt(nxt), .wrt(wrt), .cmd(cmd), .done(done),
      .rd_data(rd_data), .busy(busy), .cnv_cmplt(cnv_cmplt), .rnd_cmplt(rnd_cmplt),
      .lft_ld(lft_ld), .rght_ld(rght_ld), .steer_pot(steer_pot), .batt(batt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Tracks a conversion as a pair of acceptance windows expressed in edge
   // counts: the first done is honoured from two edges after nxt, the read
   // strobe lands GAP edges after that done, and the second done is honoured
   // from two edges after the read strobe.
   int          m_cyc  = 0;
   bit          m_busy = 1'b0;
   int          m_ph   = 0;
   int          m_acc  = 0;
   int          m_rd   = -1;
   int          m_ptr  = 0;
   logic [11:0] m_reg [4] = '{12'h0, 12'h0, 12'h0, 12'h0};
   bit          m_seed[2] = '{1'b0, 1'b0};
   logic        e_wrt = 1'b0;
   logic        e_cnv = 1'b0;
   logic        e_rnd = 1'b0;
   logic [15:0] e_cmd = 16'h0;

   function automatic logic [15:0] chan_cmd(input int p);
      int ch[4] = '{0, 4, 5, 6};
      return 16'(ch[p] * 2048);
   endfunction

   function automatic logic [11:0] filt(input logic [11:0] old, input logic [11:0] s);
      int d;
      d = int'(s) - int'(old);
      return 12'(int'(old) + (d >>> 2));
   endfunction

   task automatic model_step();
      logic [11:0] s;
      if (rst) begin
         m_busy = 1'b0; m_ph = 0; m_ptr = 0; m_rd = -1; m_acc = 0;
         for (int i = 0; i < 4; i++) m_reg[i] = 12'h000;
         m_seed[0] = 1'b0; m_seed[1] = 1'b0;
         e_wrt = 1'b0; e_cnv = 1'b0; e_rnd = 1'b0; e_cmd = 16'h0000;
      end else begin
         m_cyc++;
         e_wrt = 1'b0; e_cnv = 1'b0; e_rnd = 1'b0;
         if (!m_busy) begin
            if (nxt) begin
               m_busy = 1'b1; m_ph = 1; m_acc = m_cyc + 2;
               e_wrt = 1'b1; e_cmd = chan_cmd(m_ptr);
            end
         end else if (m_ph == 1) begin
            if (done && m_cyc >= m_acc) begin
               m_ph = 2; m_rd = m_cyc + GAP; m_acc = m_cyc + GAP + 2;
            end
         end else begin
            if (m_cyc == m_rd) e_wrt = 1'b1;
            if (done && m_cyc >= m_acc) begin
               s = rd_data[11:0];
`ifdef A2D_LD_FILT_EN
               if (m_ptr < 2 && m_seed[m_ptr]) m_reg[m_ptr] = filt(m_reg[m_ptr], s);
               else m_reg[m_ptr] = s;
               if (m_ptr < 2) m_seed[m_ptr] = 1'b1;
`else
               m_reg[m_ptr] = s;
`endif
               e_cnv = 1'b1; e_rnd = (m_ptr == 3);
               m_ptr = (m_ptr + 1) % 4; m_busy = 1'b0; m_ph = 0;
            end
         end
      end
   endtask

   always @(posedge clk or posedge rst) model_step();

   // Every cycle, all outputs against the model.
   always @(negedge clk) begin
      check("mdl wrt", wrt, e_wrt);
      check("mdl cmd", cmd, e_cmd);
      check("mdl busy", busy, m_busy);
      check("mdl cnv_cmplt", cnv_cmplt, e_cnv);
      check("mdl rnd_cmplt", rnd_cmplt, e_rnd);
      check("mdl lft_ld", lft_ld, m_reg[0]);
      check("mdl rght_ld", rght_ld, m_reg[1]);
      check("mdl steer_pot", steer_pot, m_reg[2]);
      check("mdl batt", batt, m_reg[3]);
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_wrt(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (wrt === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      check(name, ok, 1'b1);
   endtask

   // Runs one conversion; returns in the clock where cnv_cmplt is high.
   task automatic conv(input logic [15:0] rword, input logic [15:0] exp_cmd,
                       input bit noise, input string tag);
      nxt = 1'b1; tick(); nxt = 1'b0;
      wait_wrt({tag, " first wrt"});
      check({tag, " cmd word"}, cmd, exp_cmd);
      if (noise) begin done = 1'b1; tick(); done = 1'b0; end
      else tick();
      if (noise) begin nxt = 1'b1; tick(); nxt = 1'b0; end
      repeat ($urandom_range(0, 2)) tick();
      done = 1'b1; rd_data = 16'($urandom); tick(); done = 1'b0;
      if (noise) begin done = 1'b1; tick(); done = 1'b0; end
      else tick();
      check({tag, " no wrt in gap"}, wrt, 1'b0);
      tick();
      check({tag, " rd wrt at k+3"}, wrt, 1'b1);
      check({tag, " cmd stable"}, cmd, exp_cmd);
      tick();
      repeat ($urandom_range(0, 2)) tick();
      done = 1'b1; rd_data = rword;
      if (noise) nxt = 1'b1;
      tick();
      done = 1'b0; nxt = 1'b0;
      check({tag, " cnv_cmplt"}, cnv_cmplt, 1'b1);
   endtask

   logic [15:0] t2_cmd [4] = '{16'h0000, 16'h2000, 16'h2800, 16'h3000};
   logic [11:0] t2_val [4] = '{12'h111, 12'h222, 12'h333, 12'h444};
   logic [11:0] exp_l;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish (got timeout, expected finish)");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; nxt = 1'b0; done = 1'b0; rd_data = 16'h0;
      tick(); tick();
      check("reset wrt", wrt, 1'b0);
      check("reset cmd", cmd, 16'h0000);
      check("reset busy", busy, 1'b0);
      check("reset lft", lft_ld, 12'h000);
      check("reset batt", batt, 12'h000);
      rst = 1'b0; tick();

      // 1) single left conversion
      conv(16'hF123, 16'h0000, 1'b0, "t1");
      check("t1 lft_ld", lft_ld, 12'h123);
      check("t1 rnd_cmplt", rnd_cmplt, 1'b0);
      tick();
      check("t1 cnv one clk", cnv_cmplt, 1'b0);
      check("t1 idle", busy, 1'b0);

      // 2) a full round after a fresh reset; first one with busy noise
      rst = 1'b1; tick(); rst = 1'b0; tick();
      for (int i = 0; i < 4; i++) begin
         conv({4'h0, t2_val[i]}, t2_cmd[i], (i == 0), "t2");
         check("t2 rnd_cmplt", rnd_cmplt, (i == 3));
         tick();
         check("t2 back idle", busy, 1'b0);
         tick();
         check("t2 no extra wrt", wrt, 1'b0);
      end
      check("t2 lft", lft_ld, 12'h111);
      check("t2 rght", rght_ld, 12'h222);
      check("t2 steer", steer_pot, 12'h333);
      check("t2 batt", batt, 12'h444);
      conv(16'h0511, 16'h0000, 1'b1, "t2 fifth");
`ifdef A2D_LD_FILT_EN
      check("t2 fifth lft", lft_ld, 12'h211);
`else
      check("t2 fifth lft", lft_ld, 12'h511);
`endif
      tick();

      // 4) reset while WAIT_RD with done pending (right channel)
      nxt = 1'b1; tick(); nxt = 1'b0;
      check("t4 cmd rght", cmd, 16'h2000);
      tick(); done = 1'b1; tick(); done = 1'b0;
      tick(); tick();
      check("t4 rd wrt", wrt, 1'b1);
      tick();
      done = 1'b1; rd_data = 16'h0ABC;
      #2 rst = 1'b1;
      #1;
      check("t4 async busy", busy, 1'b0);
      check("t4 async cmd", cmd, 16'h0000);
      check("t4 async lft", lft_ld, 12'h000);
      check("t4 async steer", steer_pot, 12'h000);
      check("t4 async batt", batt, 12'h000);
      @(posedge clk); #1;
      check("t4 no capture", rght_ld, 12'h000);
      rst = 1'b0; done = 1'b0;
      tick();
      check("t4 idle", busy, 1'b0);

      // 5) load-cell filter (or raw) sequence, starting back at left
      conv(16'h0400, 16'h0000, 1'b0, "t5a");
      check("t5 lft first", lft_ld, 12'h400);
      conv(16'h0100, 16'h2000, 1'b0, "t5r");
      conv(16'h0200, 16'h2800, 1'b0, "t5s");
      conv(16'h0300, 16'h3000, 1'b0, "t5b");
      check("t5 rnd", rnd_cmplt, 1'b1);
      conv(16'h0800, 16'h0000, 1'b0, "t5c");
`ifdef A2D_LD_FILT_EN
      exp_l = 12'h500;
`else
      exp_l = 12'h800;
`endif
      check("t5 lft second", lft_ld, exp_l);
      conv(16'h0100, 16'h2000, 1'b0, "t5r2");
      conv(16'h0200, 16'h2800, 1'b0, "t5s2");
      conv(16'h0300, 16'h3000, 1'b0, "t5b2");
      conv(16'h0000, 16'h0000, 1'b0, "t5d");
`ifdef A2D_LD_FILT_EN
      exp_l = 12'h3C0;
`else
      exp_l = 12'h000;
`endif
      check("t5 lft third", lft_ld, exp_l);
      tick();

      // 6) done while idle changes nothing
      for (int i = 0; i < 4; i++) begin
         done = 1'b1; rd_data = 16'h0FFF; tick();
         check("t6 no wrt", wrt, 1'b0);
         check("t6 no busy", busy, 1'b0);
         check("t6 no cnv", cnv_cmplt, 1'b0);
      end
      done = 1'b0;
      check("t6 lft held", lft_ld, exp_l);
      check("t6 steer held", steer_pot, 12'h200);

      // random phase, the model does all the checking
      for (int c = 0; c < 4000; c++) begin
         nxt     = ($urandom_range(0, 5) == 0);
         done    = ($urandom_range(0, 3) == 0);
         rd_data = 16'($urandom);
         if (rst) rst = 1'b0;
         else if ($urandom_range(0, 299) == 0) rst = 1'b1;
         tick();
      end
      nxt = 1'b0; done = 1'b0; rst = 1'b0;
      repeat (4) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
